mem_port_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the fetch-stage instruction requester and the EX/MEM data requester (loads ld.b/bu/h/hu/w, stores).
- Arbitrates the address phase and holds the grant until the slave accepts.
- Tracks outstanding transactions in order and routes each data_ok/rdata beat back to its originator.
- Sits between the pipeline stages and the memory bridge. The MEM stage's load extraction consumes the routed data unchanged.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like port between the fetch requester and the
// data requester. Request and response paths are zero-latency pass-through.
// An in-order ID FIFO routes each response beat back to the requester that issued it.
module mem_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        proto_err
);

  // FIFO storage is sized for the largest legal depth; only MAX_OUTSTANDING slots are used.
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned FIFO_D = 4;

  typedef enum logic [1:0] {IDLE, HOLD_DATA, HOLD_INST} state_e;

  state_e             state_q, state_d;
  logic [FIFO_D-1:0]  fifo_q, fifo_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               proto_err_q, proto_err_d;

  logic full;
  logic empty;
  logic sel_data;
  logic sel_inst;
  logic push;
  logic pop;
  logic head;

  assign full      = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty     = (count_q == '0);
  assign head      = fifo_q[rd_ptr_q];
  assign proto_err = proto_err_q;
  assign rdata     = m_rdata;

  // Owner selection, shared port drive and next owner state; outputs forced low in reset.
  always_comb begin
    state_d      = state_q;
    sel_data     = 1'b0;
    sel_inst     = 1'b0;
    m_req        = 1'b0;
    m_wr         = 1'b0;
    m_size       = 2'd0;
    m_addr       = 32'd0;
    m_wstrb      = 4'd0;
    m_wdata      = 32'd0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!full) begin
          sel_data = data_req;
          sel_inst = !data_req && inst_req;
        end
      end
      HOLD_DATA: sel_data = 1'b1;
      HOLD_INST: sel_inst = 1'b1;
      default: ;
    endcase
    if (!resetn) begin
      sel_data = 1'b0;
      sel_inst = 1'b0;
    end
    if (sel_data) begin
      m_req   = 1'b1;
      m_wr    = data_wr;
      m_size  = data_size;
      m_addr  = data_addr;
      m_wstrb = data_wstrb;
      m_wdata = data_wdata;
    end else if (sel_inst) begin
      m_req   = 1'b1;
      m_size  = 2'd2;
      m_addr  = inst_addr;
    end
    data_addr_ok = sel_data && m_addr_ok;
    inst_addr_ok = sel_inst && m_addr_ok;
    if (m_addr_ok) begin
      state_d = IDLE;
    end else if (sel_data) begin
      state_d = HOLD_DATA;
    end else if (sel_inst) begin
      state_d = HOLD_INST;
    end
  end

  // Response routing and ID FIFO / counter / error-flag next state.
  always_comb begin
    push         = m_req && m_addr_ok;
    pop          = resetn && m_data_ok && !empty;
    inst_data_ok = pop && !head;
    data_data_ok = pop && head;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    proto_err_d  = proto_err_q || (m_data_ok && empty);
    if (push) begin
      fifo_d[wr_ptr_q] = sel_data;
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // State registers; reset discards all in-flight tracking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (MAX_OUTSTANDING = 2).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] rdata;
  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;
  logic        proto_err;

  int tests_run = 0;
  int tests_failed = 0;

  mem_port_arbiter #(.MAX_OUTSTANDING(2), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .rdata(rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are then driven and checked mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    data_req = 1; data_addr = 32'h0000_5555;
    #2;
    tests_run++;
    if (m_req !== 1'b0) begin tests_failed++; $display("FAIL reset_m_req got %b exp 0", m_req); end
    tests_run++;
    if (m_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_m_addr got %h exp 0", m_addr); end
    tests_run++;
    if (dut.count_q !== 3'd0 || proto_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_state got count=%0d perr=%b exp 0/0", dut.count_q, proto_err);
    end
    idle_inputs();
    cyc();
    resetn = 1;
    cyc();
  endtask

  task automatic test_inst_basic();
    inst_req = 1; inst_addr = 32'h1C00_0000; m_addr_ok = 1;
    #2;
    tests_run++;
    if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || m_req !== 1'b1) begin
      tests_failed++; $display("FAIL inst_accept got iok=%b dok=%b req=%b exp 1/0/1", inst_addr_ok, data_addr_ok, m_req);
    end
    tests_run++;
    if (m_addr !== 32'h1C00_0000 || m_size !== 2'd2 || m_wr !== 1'b0 || m_wstrb !== 4'd0) begin
      tests_failed++; $display("FAIL inst_fields got addr=%h size=%0d wr=%b wstrb=%h", m_addr, m_size, m_wr, m_wstrb);
    end
    cyc();
    inst_req = 0; m_addr_ok = 0;
    #2;
    tests_run++;
    if (dut.count_q !== 3'd1) begin tests_failed++; $display("FAIL inst_count1 got %0d exp 1", dut.count_q); end
    cyc();
    m_data_ok = 1; m_rdata = 32'h0280_0C0C;
    #2;
    tests_run++;
    if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || rdata !== 32'h0280_0C0C) begin
      tests_failed++; $display("FAIL inst_resp got iok=%b dok=%b rdata=%h exp 1/0/02800c0c", inst_data_ok, data_data_ok, rdata);
    end
    cyc();
    m_data_ok = 0;
    #2;
    tests_run++;
    if (dut.count_q !== 3'd0) begin tests_failed++; $display("FAIL inst_count0 got %0d exp 0", dut.count_q); end
    cyc();
  endtask

  task automatic test_priority_hold();
    inst_req = 1; inst_addr = 32'h1C00_0004;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_1004;
    m_addr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      tests_run++;
      if (m_req !== 1'b1 || m_addr !== 32'h0000_1004 || inst_addr_ok !== 1'b0) begin
        tests_failed++; $display("FAIL hold_data_%0d got req=%b addr=%h iok=%b", i, m_req, m_addr, inst_addr_ok);
      end
      cyc();
    end
    m_addr_ok = 1;
    #2;
    tests_run++;
    if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
      tests_failed++; $display("FAIL hold_data_accept got dok=%b iok=%b exp 1/0", data_addr_ok, inst_addr_ok);
    end
    cyc();
    data_req = 0; m_addr_ok = 0;
    #2;
    tests_run++;
    if (m_req !== 1'b1 || m_addr !== 32'h1C00_0004) begin
      tests_failed++; $display("FAIL rearb_inst got req=%b addr=%h exp 1/1c000004", m_req, m_addr);
    end
    cyc();
    m_addr_ok = 1;
    #2;
    tests_run++;
    if (inst_addr_ok !== 1'b1) begin tests_failed++; $display("FAIL inst_after_hold got %b exp 1", inst_addr_ok); end
    cyc();
    inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1111_2222;
    #2;
    tests_run++;
    if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin
      tests_failed++; $display("FAIL order_first got dok=%b iok=%b exp 1/0", data_data_ok, inst_data_ok);
    end
    cyc();
    m_rdata = 32'h3333_4444;
    #2;
    tests_run++;
    if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin
      tests_failed++; $display("FAIL order_second got iok=%b dok=%b exp 1/0", inst_data_ok, data_data_ok);
    end
    cyc();
    m_data_ok = 0;
    #2;
    tests_run++;
    if (dut.count_q !== 3'd0) begin tests_failed++; $display("FAIL order_count got %0d exp 0", dut.count_q); end
    cyc();
  endtask

  task automatic test_full();
    inst_req = 1; inst_addr = 32'h1C00_0010; m_addr_ok = 1;
    cyc();
    inst_req = 0; data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_2000;
    #2;
    tests_run++;
    if (data_addr_ok !== 1'b1) begin tests_failed++; $display("FAIL full_fill got dok=%b exp 1", data_addr_ok); end
    cyc();
    data_req = 0; inst_req = 1; inst_addr = 32'h1C00_0014;
    #2;
    tests_run++;
    if (m_req !== 1'b0 || inst_addr_ok !== 1'b0 || dut.count_q !== 3'd2) begin
      tests_failed++; $display("FAIL full_block got req=%b iok=%b count=%0d exp 0/0/2", m_req, inst_addr_ok, dut.count_q);
    end
    cyc();
    m_data_ok = 1; m_rdata = 32'h5555_6666;
    #2;
    tests_run++;
    if (m_req !== 1'b0 || inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin
      tests_failed++; $display("FAIL full_pop_same got req=%b iok=%b dok=%b exp 0/1/0", m_req, inst_data_ok, data_data_ok);
    end
    cyc();
    m_data_ok = 0; m_addr_ok = 0;
    #2;
    tests_run++;
    if (dut.count_q !== 3'd1 || m_req !== 1'b1 || m_addr !== 32'h1C00_0014) begin
      tests_failed++; $display("FAIL full_release got count=%0d req=%b addr=%h exp 1/1/1c000014", dut.count_q, m_req, m_addr);
    end
    cyc();
    m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h7777_8888;
    #2;
    tests_run++;
    if (inst_addr_ok !== 1'b1 || data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin
      tests_failed++; $display("FAIL push_pop got iaok=%b ddok=%b idok=%b exp 1/1/0", inst_addr_ok, data_data_ok, inst_data_ok);
    end
    cyc();
    inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
    #2;
    tests_run++;
    if (dut.count_q !== 3'd1 || inst_data_ok !== 1'b1) begin
      tests_failed++; $display("FAIL push_pop_count got count=%0d iok=%b exp 1/1", dut.count_q, inst_data_ok);
    end
    cyc();
    m_data_ok = 0;
    #2;
    tests_run++;
    if (dut.count_q !== 3'd0) begin tests_failed++; $display("FAIL full_drain got %0d exp 0", dut.count_q); end
    cyc();
  endtask

  task automatic test_store();
    inst_req = 1; inst_addr = 32'h1C00_0020;
    data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h0000_2003;
    data_wstrb = 4'b1000; data_wdata = 32'hAB00_0000; m_addr_ok = 0;
    for (int i = 0; i < 2; i++) begin
      #2;
      tests_run++;
      if (m_wr !== 1'b1 || m_wstrb !== 4'b1000 || m_wdata !== 32'hAB00_0000 || m_size !== 2'd0 || m_addr !== 32'h0000_2003) begin
        tests_failed++; $display("FAIL store_fields_%0d got wr=%b wstrb=%b wdata=%h size=%0d addr=%h", i, m_wr, m_wstrb, m_wdata, m_size, m_addr);
      end
      cyc();
    end
    m_addr_ok = 1;
    #2;
    tests_run++;
    if (data_addr_ok !== 1'b1) begin tests_failed++; $display("FAIL store_accept got %b exp 1", data_addr_ok); end
    cyc();
    inst_req = 0; data_req = 0; data_wr = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h0;
    #2;
    tests_run++;
    if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin
      tests_failed++; $display("FAIL store_done got dok=%b iok=%b exp 1/0", data_data_ok, inst_data_ok);
    end
    cyc();
    m_data_ok = 0;
    #2;
    tests_run++;
    if (dut.count_q !== 3'd0) begin tests_failed++; $display("FAIL store_pop got %0d exp 0", dut.count_q); end
    cyc();
  endtask

  task automatic test_stray_and_reset();
    m_data_ok = 1; m_rdata = 32'hDEAD_BEEF;
    #2;
    tests_run++;
    if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
      tests_failed++; $display("FAIL stray_route got iok=%b dok=%b exp 0/0", inst_data_ok, data_data_ok);
    end
    cyc();
    m_data_ok = 0;
    cyc();
    #1;
    tests_run++;
    if (proto_err !== 1'b1 || dut.count_q !== 3'd0) begin
      tests_failed++; $display("FAIL stray_sticky got perr=%b count=%0d exp 1/0", proto_err, dut.count_q);
    end
    inst_req = 1; inst_addr = 32'h1C00_0030; m_addr_ok = 1;
    cyc();
    inst_req = 0; data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_3000; m_addr_ok = 0;
    cyc();
    #1;
    tests_run++;
    if (m_req !== 1'b1 || m_addr !== 32'h0000_3000 || dut.count_q !== 3'd1 || dut.state_q !== dut.HOLD_DATA) begin
      tests_failed++; $display("FAIL pre_reset_hold got req=%b addr=%h count=%0d", m_req, m_addr, dut.count_q);
    end
    resetn = 0; m_addr_ok = 1;
    #1;
    tests_run++;
    if (m_req !== 1'b0 || data_addr_ok !== 1'b0 || proto_err !== 1'b0 || dut.count_q !== 3'd0) begin
      tests_failed++; $display("FAIL async_reset got req=%b dok=%b perr=%b count=%0d exp 0/0/0/0", m_req, data_addr_ok, proto_err, dut.count_q);
    end
    idle_inputs();
    cyc();
    resetn = 1;
    m_data_ok = 1;
    #2;
    tests_run++;
    if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
      tests_failed++; $display("FAIL post_reset_route got iok=%b dok=%b exp 0/0", inst_data_ok, data_data_ok);
    end
    cyc();
    m_data_ok = 0;
  endtask

  initial begin
    test_reset();
    test_inst_basic();
    test_priority_hold();
    test_full();
    test_store();
    test_stray_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
